ft_245_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single FT245 USB write path between up to `NUM_REQ` on-chip byte producers. It sits between the requesters and `ft_245_state_machine`:
- it drives that block's `WRITE_EN`/`WRITE_BYTE` and consumes `WRITE_COMPLETE`;
- it holds off new reads through `ENDPOINT_BUSY` while a write burst owns the bus.

Requesters may hold a grant for a multi-byte packet, bounded by `MAX_BURST` so no producer can starve the others.

---
 rtl/ft_245_tx_arbiter_pkg.sv | 22 ++
 rtl/ft_245_tx_arbiter_if.sv | 31 +++
 rtl/rr_priority_select.sv | 34 +++
 rtl/ft_245_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_ft_245_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft_245_tx_arbiter_pkg.sv
// Shared constants for the FT245 transmit arbiter: state encoding, default
// sizing and the wrap-around index helper used by the round-robin selector.
package ft_245_tx_arbiter_pkg;

  localparam int FT_NUM_REQ_DEFAULT   = 4;
  localparam int FT_MAX_BURST_DEFAULT = 16;
  localparam int FT_BURST_CNT_W       = 8;
  localparam int FT_BYTE_CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned modulus);
    return (base + step) % modulus;
  endfunction

endpackage

// File: rtl/ft_245_tx_arbiter_if.sv
// Requester and FT245 write-path signals of the transmit arbiter.
// master is the arbiter side; slave is the requesters plus FT245 machine.
interface ft_245_tx_arbiter_if
  import ft_245_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = FT_NUM_REQ_DEFAULT
);

  logic [NUM_REQ-1:0]       REQ_VALID;
  logic [8*NUM_REQ-1:0]     REQ_BYTE;
  logic [NUM_REQ-1:0]       REQ_LAST;
  logic [NUM_REQ-1:0]       REQ_ACK;
  logic [NUM_REQ-1:0]       GRANT;
  logic                     WRITE_EN;
  logic [7:0]               WRITE_BYTE;
  logic                     WRITE_COMPLETE;
  logic                     FT_245_SM_BUSY;
  logic                     ENDPOINT_BUSY;
  logic [FT_BYTE_CNT_W-1:0] BYTE_COUNT;

  modport master (
    input  REQ_VALID, REQ_BYTE, REQ_LAST, WRITE_COMPLETE, FT_245_SM_BUSY,
    output REQ_ACK, GRANT, WRITE_EN, WRITE_BYTE, ENDPOINT_BUSY, BYTE_COUNT
  );

  modport slave (
    output REQ_VALID, REQ_BYTE, REQ_LAST, WRITE_COMPLETE, FT_245_SM_BUSY,
    input  REQ_ACK, GRANT, WRITE_EN, WRITE_BYTE, ENDPOINT_BUSY, BYTE_COUNT
  );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first valid requester strictly after
// last_owner, scanning upwards and wrapping.
module rr_priority_select
  import ft_245_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = FT_NUM_REQ_DEFAULT,
  parameter int IDX_W   = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               winner_found
);

  logic [IDX_W-1:0] cand_idx;

  // Offset k=NUM_REQ lands back on last_owner, so it wins only when alone.
  always_comb begin
    winner_onehot = '0;
    winner_idx    = '0;
    winner_found  = 1'b0;
    cand_idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'(wrap_add(32'(last_owner), k, NUM_REQ));
      if (!winner_found && valid[cand_idx]) begin
        winner_found            = 1'b1;
        winner_idx              = cand_idx;
        winner_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ft_245_tx_arbiter.sv
// Round-robin arbiter sharing the FT245 write path between NUM_REQ byte
// producers, with per-grant bursts capped at MAX_BURST bytes.
module ft_245_tx_arbiter
  import ft_245_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = FT_NUM_REQ_DEFAULT,
  parameter int MAX_BURST = FT_MAX_BURST_DEFAULT
)(
  input  logic                CLK,
  input  logic                RST_N,
  ft_245_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]          LAST_OWNER_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [FT_BURST_CNT_W-1:0] BURST_LIMIT    = FT_BURST_CNT_W'(MAX_BURST);

  arb_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [NUM_REQ-1:0]       last_flag_q, last_flag_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         last_owner_q, last_owner_d;
  logic                     write_en_q, write_en_d;
  logic [7:0]               write_byte_q, write_byte_d;
  logic                     busy_q, busy_d;
  logic [FT_BYTE_CNT_W-1:0] byte_count_q, byte_count_d;
  logic [FT_BURST_CNT_W-1:0] burst_q, burst_d;

  logic [NUM_REQ-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [7:0]         winner_byte;
  logic [7:0]         owner_byte;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_select (
    .valid         (bus.REQ_VALID),
    .last_owner    (last_owner_q),
    .winner_onehot (sel_onehot),
    .winner_idx    (sel_idx),
    .winner_found  (sel_found)
  );

  always_comb begin
    winner_byte = '0;
    owner_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) winner_byte = bus.REQ_BYTE[8*i +: 8];
      if (owner_q == IDX_W'(i)) owner_byte  = bus.REQ_BYTE[8*i +: 8];
    end
  end

  // REQ_VALID is only looked at in IDLE and RELEASE, so a byte already
  // presented to the FT245 machine can never be pulled back.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = '0;
    last_flag_d  = last_flag_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    write_en_d   = write_en_q;
    write_byte_d = write_byte_q;
    busy_d       = busy_q;
    byte_count_d = byte_count_q;
    burst_d      = burst_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (sel_found && !bus.FT_245_SM_BUSY) begin
          grant_d      = sel_onehot;
          owner_d      = sel_idx;
          write_byte_d = winner_byte;
          write_en_d   = 1'b1;
          busy_d       = 1'b1;
          burst_d      = '0;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (bus.WRITE_COMPLETE) begin
          write_en_d           = 1'b0;
          ack_d[owner_q]       = 1'b1;
          last_flag_d[owner_q] = bus.REQ_LAST[owner_q];
          byte_count_d         = byte_count_q + 1'b1;
          burst_d              = burst_q + 1'b1;
          state_d              = ST_RELEASE;
        end
      end

      // Waiting for WRITE_COMPLETE to drop keeps the FT245 machine from
      // seeing a fresh WRITE_EN before it has returned to its own idle.
      ST_RELEASE: begin
        if (!bus.WRITE_COMPLETE) begin
          if (bus.REQ_VALID[owner_q] && !last_flag_q[owner_q] &&
              (burst_q < BURST_LIMIT)) begin
            write_byte_d = owner_byte;
            write_en_d   = 1'b1;
            state_d      = ST_ISSUE;
          end else begin
            last_owner_d = owner_q;
            grant_d      = '0;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      last_flag_q  <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_OWNER_RST;
      write_en_q   <= 1'b0;
      write_byte_q <= '0;
      busy_q       <= 1'b0;
      byte_count_q <= '0;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      last_flag_q  <= last_flag_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      write_en_q   <= write_en_d;
      write_byte_q <= write_byte_d;
      busy_q       <= busy_d;
      byte_count_q <= byte_count_d;
      burst_q      <= burst_d;
    end
  end

  assign bus.REQ_ACK       = ack_q;
  assign bus.GRANT         = grant_q;
  assign bus.WRITE_EN      = write_en_q;
  assign bus.WRITE_BYTE    = write_byte_q;
  assign bus.ENDPOINT_BUSY = busy_q;
  assign bus.BYTE_COUNT    = byte_count_q;

endmodule

// File: tb/tb_ft_245_tx_arbiter.sv
// Directed bench for ft_245_tx_arbiter: requester queues and an FT245 write
// model run in one background loop; each scenario task checks its own results.
`timescale 1ns/1ps
module tb_ft_245_tx_arbiter;
  import ft_245_tx_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXB = 4;

  typedef enum int {FT_IDLE, FT_WAIT, FT_HOLD} ft_state_t;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  ft_245_tx_arbiter_if #(.NUM_REQ(NREQ)) bus();

  ft_245_tx_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(MAXB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int         rem[NREQ];
  int         sent[NREQ];
  int         ack_cnt[NREQ];
  logic [7:0] base[NREQ];
  bit         last_each[NREQ];
  int         ack_order[$];
  logic [7:0] wr_bytes[$];
  int         viol;
  int         ft_delay;
  int         ft_hold;
  int         ft_cnt;
  ft_state_t  ft_state;

  task automatic refresh_req();
    for (int i = 0; i < NREQ; i++) begin
      bus.REQ_VALID[i]      = (rem[i] > 0);
      bus.REQ_BYTE[8*i +: 8] = base[i] + 8'(sent[i]);
      bus.REQ_LAST[i]       = (rem[i] > 0) && (last_each[i] || rem[i] == 1);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; sent[i] = 0; ack_cnt[i] = 0;
      base[i] = 8'((i + 1) * 16); last_each[i] = 1'b0;
    end
    ack_order.delete();
    wr_bytes.delete();
    viol = 0; ft_delay = 2; ft_hold = 0; ft_cnt = 0; ft_state = FT_IDLE;
    bus.WRITE_COMPLETE = 1'b0;
    bus.FT_245_SM_BUSY = 1'b0;
    refresh_req();
  endtask

  function automatic bit quiet();
    bit q;
    q = (ft_state == FT_IDLE) && !bus.ENDPOINT_BUSY && !bus.WRITE_EN;
    for (int i = 0; i < NREQ; i++) if (rem[i] != 0) q = 1'b0;
    return q;
  endfunction

  // Requesters advance on an observed ack; the FT245 model completes a write
  // ft_delay cycles after WRITE_EN and holds WRITE_COMPLETE ft_hold extra cycles.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (!RST_N) begin
        ft_state = FT_IDLE;
        bus.WRITE_COMPLETE = 1'b0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (bus.REQ_ACK[i]) begin
            ack_cnt[i]++;
            ack_order.push_back(i);
            if (rem[i] > 0) begin rem[i]--; sent[i]++; end
          end
        end
        refresh_req();
        case (ft_state)
          FT_IDLE: if (bus.WRITE_EN) begin ft_cnt = ft_delay; ft_state = FT_WAIT; end
          FT_WAIT: begin
            if (ft_cnt <= 1) begin
              bus.WRITE_COMPLETE = 1'b1;
              wr_bytes.push_back(bus.WRITE_BYTE);
              ft_cnt = ft_hold;
              ft_state = FT_HOLD;
            end else ft_cnt--;
          end
          default: begin
            if (bus.WRITE_EN) viol++;
            if (ft_cnt == 0) begin bus.WRITE_COMPLETE = 1'b0; ft_state = FT_IDLE; end
            else ft_cnt--;
          end
        endcase
      end
    end
  end

  task automatic do_reset();
    RST_N = 1'b0;
    clear_model();
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK); #2;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (n < budget && !quiet()) begin @(posedge CLK); #2; n++; end
    if (n >= budget) begin
      failures++;
      $display("[TB] FAIL %s_timeout got=busy after %0d cycles exp=idle", name, n);
    end
    checks++;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    clear_model();
    repeat (3) @(posedge CLK);
    #2;
    if (bus.GRANT !== 4'b0000) begin failures++; $display("[TB] FAIL rst_grant got=%b exp=0000", bus.GRANT); end
    checks++;
    if (bus.REQ_ACK !== 4'b0000) begin failures++; $display("[TB] FAIL rst_ack got=%b exp=0000", bus.REQ_ACK); end
    checks++;
    if (bus.WRITE_EN !== 1'b0) begin failures++; $display("[TB] FAIL rst_write_en got=%b exp=0", bus.WRITE_EN); end
    checks++;
    if (bus.WRITE_BYTE !== 8'h00) begin failures++; $display("[TB] FAIL rst_write_byte got=%h exp=00", bus.WRITE_BYTE); end
    checks++;
    if (bus.ENDPOINT_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL rst_ep_busy got=%b exp=0", bus.ENDPOINT_BUSY); end
    checks++;
    if (bus.BYTE_COUNT !== 16'd0) begin failures++; $display("[TB] FAIL rst_byte_count got=%0d exp=0", bus.BYTE_COUNT); end
    checks++;
    RST_N = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [7:0] got;
    ft_delay = 5;
    base[0]  = 8'hA5;
    rem[0]   = 1;
    refresh_req();
    @(posedge CLK); #2;
    if (bus.WRITE_EN !== 1'b1) begin failures++; $display("[TB] FAIL sb_grant_latency got=%b exp=1", bus.WRITE_EN); end
    checks++;
    if (bus.GRANT !== 4'b0001) begin failures++; $display("[TB] FAIL sb_grant got=%b exp=0001", bus.GRANT); end
    checks++;
    if (bus.WRITE_BYTE !== 8'hA5) begin failures++; $display("[TB] FAIL sb_write_byte got=%h exp=a5", bus.WRITE_BYTE); end
    checks++;
    if (bus.ENDPOINT_BUSY !== 1'b1) begin failures++; $display("[TB] FAIL sb_ep_busy_rise got=%b exp=1", bus.ENDPOINT_BUSY); end
    checks++;
    wait_done(100, "sb");
    if (ack_cnt[0] != 1) begin failures++; $display("[TB] FAIL sb_ack_cycles got=%0d exp=1", ack_cnt[0]); end
    checks++;
    if (bus.BYTE_COUNT !== 16'd1) begin failures++; $display("[TB] FAIL sb_byte_count got=%0d exp=1", bus.BYTE_COUNT); end
    checks++;
    if (bus.ENDPOINT_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL sb_ep_busy_fall got=%b exp=0", bus.ENDPOINT_BUSY); end
    checks++;
    got = (wr_bytes.size() > 0) ? wr_bytes[0] : 8'h00;
    if (got !== 8'hA5) begin failures++; $display("[TB] FAIL sb_ft_byte got=%h exp=a5", got); end
    checks++;
  endtask

  task automatic test_round_robin();
    int         exp_order[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_bytes[5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11};
    int         got;
    logic [7:0] gotb;
    do_reset();
    last_each[0] = 1'b1;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    refresh_req();
    wait_done(400, "rr");
    for (int k = 0; k < 5; k++) begin
      got  = (k < ack_order.size()) ? ack_order[k] : -1;
      gotb = (k < wr_bytes.size()) ? wr_bytes[k] : 8'h00;
      if (got != exp_order[k]) begin failures++; $display("[TB] FAIL rr_order[%0d] got=%0d exp=%0d", k, got, exp_order[k]); end
      checks++;
      if (gotb !== exp_bytes[k]) begin failures++; $display("[TB] FAIL rr_byte[%0d] got=%h exp=%h", k, gotb, exp_bytes[k]); end
      checks++;
    end
    if (bus.BYTE_COUNT !== 16'd5) begin failures++; $display("[TB] FAIL rr_byte_count got=%0d exp=5", bus.BYTE_COUNT); end
    checks++;
  endtask

  task automatic test_burst_cap();
    int         exp_order[11] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2};
    logic [7:0] exp_bytes[11] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h20, 8'h34,
                                  8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    int         got;
    int         n = 0;
    logic [7:0] gotb;
    do_reset();
    rem[2] = 10;
    refresh_req();
    while (ack_order.size() == 0 && n < 100) begin @(posedge CLK); #2; n++; end
    if (ack_order.size() == 0) begin failures++; $display("[TB] FAIL cap_first_ack got=0 acks exp=1"); end
    checks++;
    rem[1] = 1;
    refresh_req();
    wait_done(800, "cap");
    for (int k = 0; k < 11; k++) begin
      got  = (k < ack_order.size()) ? ack_order[k] : -1;
      gotb = (k < wr_bytes.size()) ? wr_bytes[k] : 8'h00;
      if (got != exp_order[k]) begin failures++; $display("[TB] FAIL cap_order[%0d] got=%0d exp=%0d", k, got, exp_order[k]); end
      checks++;
      if (gotb !== exp_bytes[k]) begin failures++; $display("[TB] FAIL cap_byte[%0d] got=%h exp=%h", k, gotb, exp_bytes[k]); end
      checks++;
    end
    if (bus.BYTE_COUNT !== 16'd11) begin failures++; $display("[TB] FAIL cap_byte_count got=%0d exp=11", bus.BYTE_COUNT); end
    checks++;
  endtask

  task automatic test_read_busy();
    do_reset();
    bus.FT_245_SM_BUSY = 1'b1;
    rem[1] = 2;
    refresh_req();
    repeat (4) @(posedge CLK);
    #2;
    if (bus.WRITE_EN !== 1'b0) begin failures++; $display("[TB] FAIL rb_hold_write_en got=%b exp=0", bus.WRITE_EN); end
    checks++;
    if (bus.GRANT !== 4'b0000) begin failures++; $display("[TB] FAIL rb_hold_grant got=%b exp=0000", bus.GRANT); end
    checks++;
    bus.FT_245_SM_BUSY = 1'b0;
    @(posedge CLK); #2;
    if (bus.WRITE_EN !== 1'b1) begin failures++; $display("[TB] FAIL rb_release_write_en got=%b exp=1", bus.WRITE_EN); end
    checks++;
    if (bus.GRANT !== 4'b0010) begin failures++; $display("[TB] FAIL rb_release_grant got=%b exp=0010", bus.GRANT); end
    checks++;
    bus.FT_245_SM_BUSY = 1'b1;
    wait_done(300, "rb");
    if (ack_cnt[1] != 2) begin failures++; $display("[TB] FAIL rb_burst_acks got=%0d exp=2", ack_cnt[1]); end
    checks++;
    if (bus.BYTE_COUNT !== 16'd2) begin failures++; $display("[TB] FAIL rb_byte_count got=%0d exp=2", bus.BYTE_COUNT); end
    checks++;
    bus.FT_245_SM_BUSY = 1'b0;
  endtask

  task automatic test_complete_hold();
    int got;
    do_reset();
    ft_hold = 2;
    rem[0] = 2; rem[3] = 1;
    refresh_req();
    wait_done(400, "hold");
    if (ack_cnt[0] != 2) begin failures++; $display("[TB] FAIL hold_acks0 got=%0d exp=2", ack_cnt[0]); end
    checks++;
    if (ack_cnt[3] != 1) begin failures++; $display("[TB] FAIL hold_acks3 got=%0d exp=1", ack_cnt[3]); end
    checks++;
    if (bus.BYTE_COUNT !== 16'd3) begin failures++; $display("[TB] FAIL hold_byte_count got=%0d exp=3", bus.BYTE_COUNT); end
    checks++;
    if (wr_bytes.size() != 3) begin failures++; $display("[TB] FAIL hold_writes got=%0d exp=3", wr_bytes.size()); end
    checks++;
    if (viol != 0) begin failures++; $display("[TB] FAIL hold_early_write_en got=%0d exp=0", viol); end
    checks++;
    got = (ack_order.size() > 2) ? ack_order[2] : -1;
    if (got != 3) begin failures++; $display("[TB] FAIL hold_third_owner got=%0d exp=3", got); end
    checks++;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    do_reset();
    ft_delay = 4;
    rem[2] = 5;
    refresh_req();
    while (bus.WRITE_EN !== 1'b1 && n < 20) begin @(posedge CLK); #2; n++; end
    @(posedge CLK); #2;
    RST_N = 1'b0;
    rem[0] = 1;
    refresh_req();
    #1;
    if (bus.WRITE_EN !== 1'b0) begin failures++; $display("[TB] FAIL mrst_write_en got=%b exp=0", bus.WRITE_EN); end
    checks++;
    if (bus.GRANT !== 4'b0000) begin failures++; $display("[TB] FAIL mrst_grant got=%b exp=0000", bus.GRANT); end
    checks++;
    if (bus.ENDPOINT_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL mrst_ep_busy got=%b exp=0", bus.ENDPOINT_BUSY); end
    checks++;
    if (bus.BYTE_COUNT !== 16'd0) begin failures++; $display("[TB] FAIL mrst_byte_count got=%0d exp=0", bus.BYTE_COUNT); end
    checks++;
    @(posedge CLK); #2;
    if (ack_cnt[2] != 0) begin failures++; $display("[TB] FAIL mrst_no_ack got=%0d exp=0", ack_cnt[2]); end
    checks++;
    RST_N = 1'b1;
    @(posedge CLK); #2;
    if (bus.GRANT !== 4'b0001) begin failures++; $display("[TB] FAIL mrst_first_grant got=%b exp=0001", bus.GRANT); end
    checks++;
    if (bus.WRITE_BYTE !== 8'h10) begin failures++; $display("[TB] FAIL mrst_first_byte got=%h exp=10", bus.WRITE_BYTE); end
    checks++;
    wait_done(400, "mrst");
    if (ack_cnt[2] != 5) begin failures++; $display("[TB] FAIL mrst_req2_acks got=%0d exp=5", ack_cnt[2]); end
    checks++;
    if (bus.BYTE_COUNT !== 16'd6) begin failures++; $display("[TB] FAIL mrst_byte_count got=%0d exp=6", bus.BYTE_COUNT); end
    checks++;
  endtask

  initial begin
    RST_N = 1'b0;
    clear_model();
    test_reset();
    test_single_byte();
    test_round_robin();
    test_burst_cap();
    test_read_busy();
    test_complete_hold();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
